wash_actuator_ctrl: RTL and testbench

Actuator sequencer for the washing-machine controller. Takes the cycle FSM's phase code (0–6) and a 1 Hz tick, then drives the physical actuators: water valves, drain pump, motor, and lid lock. It owns the lid-lock handshake, motor agitation reversal and the safety interlocks. It asks the cycle FSM to freeze its seconds counter (`hold`) whenever the machine must not be timing a phase.

---
 rtl/wash_actuator_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_wash_actuator_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_actuator_ctrl.sv
// Washing-machine actuator sequencer: lid-lock handshake, agitation reversal and interlocks.
// Optional build macro ACT_LOCK_FEEDBACK_EN adds the lid_locked sensor input.
module wash_actuator_ctrl #(
  parameter int AGIT_SEC = 2,
  parameter int LOCK_SEC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] phase,
  input  logic [1:0] temp,
  input  logic       lid_open,
`ifdef ACT_LOCK_FEEDBACK_EN
  input  logic       lid_locked,
`endif
  output logic       hot_valve,
  output logic       cold_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       lid_lock,
  output logic       hold,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, LOCKING, RUN, UNLOCKING, FAULT} state_t;

  localparam logic [3:0] AGIT_LIM = 4'(AGIT_SEC);
  localparam logic [3:0] LOCK_LIM = 4'(LOCK_SEC);

  state_t     state, state_nx;
  logic [3:0] tcnt, tcnt_nx, tcnt_inc;
  logic       fresh;
  logic [3:0] agit_cnt, agit_cnt_nx;
  logic       agit_dir, agit_dir_nx;
  logic [2:0] phase_q;
  logic       off_req, tick_ok, tick_done, fill_bad, lock_lost, agit_on;
  logic       hot_nx, cold_nx, drain_nx, en_nx, dir_nx, fast_nx, lock_nx, hold_nx, fault_nx;

  // A tick in the first cycle of a state is ignored; counters saturate at 15.
  assign off_req   = (phase == 3'd0) || (phase == 3'd7);
  assign tick_ok   = tick && !fresh;
  assign tcnt_inc  = (tcnt == 4'd15) ? 4'd15 : tcnt + 4'd1;
  assign tick_done = tick_ok && (tcnt_inc >= LOCK_LIM);
  assign fill_bad  = (phase == 3'd1) && (temp == 2'b11);
`ifdef ACT_LOCK_FEEDBACK_EN
  assign lock_lost = !lid_locked;
`else
  assign lock_lost = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!off_req && !lid_open) state_nx = LOCKING;
      LOCKING: begin
        if (lid_open)     state_nx = FAULT;
        else if (off_req) state_nx = IDLE;
`ifdef ACT_LOCK_FEEDBACK_EN
        else if (lid_locked)                         state_nx = RUN;
        else if (tick_ok && (tcnt_inc >= 4'd3))      state_nx = FAULT;
`else
        else if (tick_done) state_nx = RUN;
`endif
      end
      RUN: begin
        if (lid_open || fill_bad || lock_lost) state_nx = FAULT;
        else if (off_req)                      state_nx = UNLOCKING;
      end
      UNLOCKING: begin
        if (tick_done)     state_nx = IDLE;
        else if (!off_req) state_nx = RUN;
      end
      FAULT:     if (off_req) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    tcnt_nx     = (state_nx != state) ? 4'd0 : (tick_ok ? tcnt_inc : tcnt);
    agit_cnt_nx = agit_cnt;
    agit_dir_nx = agit_dir;
    if ((state_nx != RUN) || (state != RUN) || (phase != phase_q)) begin
      agit_cnt_nx = 4'd0;
      agit_dir_nx = 1'b0;
    end else if (tick) begin
      if (agit_cnt >= AGIT_LIM) begin
        agit_cnt_nx = 4'd0;
        agit_dir_nx = !agit_dir;
      end else begin
        agit_cnt_nx = agit_cnt + 4'd1;
      end
    end
  end

  assign agit_on = (agit_cnt_nx < AGIT_LIM);

  // Output decode from the state being entered so outputs land with it.
  always_comb begin
    hot_nx   = 1'b0;
    cold_nx  = 1'b0;
    drain_nx = 1'b0;
    en_nx    = 1'b0;
    dir_nx   = 1'b0;
    fast_nx  = 1'b0;
    lock_nx  = 1'b0;
    hold_nx  = 1'b0;
    fault_nx = 1'b0;
    case (state_nx)
      IDLE:      hold_nx = !off_req;
      LOCKING: begin
        lock_nx = 1'b1;
        hold_nx = 1'b1;
      end
      RUN: begin
        lock_nx = 1'b1;
        case (phase)
          3'd1: begin
            hot_nx  = (temp == 2'b00) || (temp == 2'b01);
            cold_nx = (temp == 2'b01) || (temp == 2'b10);
          end
          3'd2: begin
            en_nx  = agit_on;
            dir_nx = agit_dir_nx;
          end
          3'd3, 3'd4: begin
            cold_nx = 1'b1;
            en_nx   = agit_on;
            dir_nx  = agit_dir_nx;
          end
          3'd5, 3'd6: begin
            drain_nx = 1'b1;
            en_nx    = 1'b1;
            fast_nx  = 1'b1;
          end
          default: ;
        endcase
      end
      UNLOCKING: lock_nx = 1'b1;
      FAULT: begin
        fault_nx = 1'b1;
        hold_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tcnt       <= 4'd0;
      fresh      <= 1'b0;
      agit_cnt   <= 4'd0;
      agit_dir   <= 1'b0;
      phase_q    <= 3'd0;
      hot_valve  <= 1'b0;
      cold_valve <= 1'b0;
      drain_pump <= 1'b0;
      motor_en   <= 1'b0;
      motor_dir  <= 1'b0;
      motor_fast <= 1'b0;
      lid_lock   <= 1'b0;
      hold       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      tcnt       <= tcnt_nx;
      fresh      <= (state_nx != state);
      agit_cnt   <= agit_cnt_nx;
      agit_dir   <= agit_dir_nx;
      phase_q    <= phase;
      hot_valve  <= hot_nx;
      cold_valve <= cold_nx;
      drain_pump <= drain_nx;
      motor_en   <= en_nx;
      motor_dir  <= dir_nx;
      motor_fast <= fast_nx;
      lid_lock   <= lock_nx;
      hold       <= hold_nx;
      fault      <= fault_nx;
    end
  end

endmodule

// File: tb/tb_wash_actuator_ctrl.sv
// Bench for wash_actuator_ctrl: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a behavioural model.
module tb_wash_actuator_ctrl;
  localparam int A = 2;
  localparam int L = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] phase = 3'd0;
  logic [1:0] temp = 2'd0;
  logic       lid_open = 1'b0;
`ifdef ACT_LOCK_FEEDBACK_EN
  logic       lid_locked = 1'b1;
`endif
  logic hot_valve, cold_valve, drain_pump, motor_en, motor_dir, motor_fast, lid_lock, hold, fault;

  wash_actuator_ctrl #(.AGIT_SEC(A), .LOCK_SEC(L)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .phase(phase), .temp(temp), .lid_open(lid_open),
`ifdef ACT_LOCK_FEEDBACK_EN
    .lid_locked(lid_locked),
`endif
    .hot_valve(hot_valve), .cold_valve(cold_valve), .drain_pump(drain_pump),
    .motor_en(motor_en), .motor_dir(motor_dir), .motor_fast(motor_fast),
    .lid_lock(lid_lock), .hold(hold), .fault(fault)
  );

  always #5 clk = ~clk;

  int lit_tests = 0, lit_fails = 0;
  int cmp_tests = 0, cmp_fails = 0;
  int total_tests, total_fails;
  bit chk_en = 1'b0;
  int cycle = 0;

  // Behavioural model. Modes: 0 idle, 1 locking, 2 run, 3 unlocking, 4 fault.
  int   m_mode, m_ticks, m_k;
  bit   m_entry;
  logic [2:0] m_pph;
  logic [8:0] e_vec;  // {hot,cold,drain,en,dir,fast,lock,hold,fault}

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_ticks = 0; m_k = 0; m_entry = 0; m_pph = 3'd0; e_vec = 9'd0;
    end else begin
      bit pz, counted, ag_on, ag_dir, lost;
      int nt, nm;
      cycle++;
      pz = (phase == 3'd0) || (phase == 3'd7);
      counted = tick && !m_entry;
      nt = counted ? ((m_ticks < 15) ? m_ticks + 1 : 15) : m_ticks;
      lost = 1'b0;
`ifdef ACT_LOCK_FEEDBACK_EN
      lost = !lid_locked;
`endif
      nm = m_mode;
      case (m_mode)
        0: if (!pz && !lid_open) nm = 1;
        1: begin
          if (lid_open) nm = 4;
          else if (pz) nm = 0;
`ifdef ACT_LOCK_FEEDBACK_EN
          else if (lid_locked) nm = 2;
          else if (counted && nt >= 3) nm = 4;
`else
          else if (counted && nt >= L) nm = 2;
`endif
        end
        2: if (lid_open || lost || (phase == 3'd1 && temp == 2'b11)) nm = 4;
           else if (pz) nm = 3;
        3: if (counted && nt >= L) nm = 0;
           else if (!pz) nm = 2;
        default: if (pz) nm = 0;
      endcase
      if (nm == 2 && m_mode == 2 && phase == m_pph) m_k += int'(tick);
      else m_k = 0;
      m_ticks = (nm != m_mode) ? 0 : nt;
      m_entry = (nm != m_mode);
      m_mode  = nm;
      m_pph   = phase;
      // Agitation: period of 2*(A+1) ticks, first A of each half driving.
      ag_on  = (m_k % (A + 1)) < A;
      ag_dir = (m_k % (2 * (A + 1))) >= (A + 1);
      e_vec = 9'd0;
      case (m_mode)
        0: e_vec[1] = !pz;
        1: e_vec = 9'b000000110;
        2: begin
          e_vec[2] = 1'b1;
          case (phase)
            3'd1: begin
              e_vec[8] = (temp == 2'b00) || (temp == 2'b01);
              e_vec[7] = (temp == 2'b01) || (temp == 2'b10);
            end
            3'd2: begin e_vec[5] = ag_on; e_vec[4] = ag_dir; end
            3'd3, 3'd4: begin e_vec[7] = 1'b1; e_vec[5] = ag_on; e_vec[4] = ag_dir; end
            3'd5, 3'd6: begin e_vec[6] = 1'b1; e_vec[5] = 1'b1; e_vec[3] = 1'b1; end
            default: ;
          endcase
        end
        3: e_vec[2] = 1'b1;
        default: e_vec = 9'b000000011;
      endcase
    end
  end

  function automatic logic [8:0] outs();
    return {hot_valve, cold_valve, drain_pump, motor_en, motor_dir, motor_fast, lid_lock, hold, fault};
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      logic [8:0] got, msk;
      got = outs();
      msk = e_vec[5] ? 9'h1FF : 9'h1EF;
      cmp_tests++;
      if ((got & msk) !== (e_vec & msk)) begin
        cmp_fails++;
        $display("FAIL model_cmp cycle=%0d got=%b exp=%b", cycle, got, e_vec);
      end
      cmp_tests++;
      if ((hot_valve && drain_pump) || (motor_fast && !motor_en)) begin
        cmp_fails++;
        $display("FAIL interlock cycle=%0d got=%b", cycle, got);
      end
    end
  end

  task automatic lit(input string nm, input logic [8:0] got, input logic [8:0] exp);
    lit_tests++;
    if (got !== exp) begin
      lit_fails++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  bit en_pat [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
  bit dir_pat[8] = '{0, 0, 0, 1, 1, 0, 0, 0};

  initial begin
    step(2);
    lit("reset_outputs", outs(), 9'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(1);

    phase = 3'd1; temp = 2'b01;
    step(1);
    lit("lock_hold", {8'd0, hold}, 9'd1);
    lit("lock_solenoid", {8'd0, lid_lock}, 9'd1);
    lit("lock_valves_off", {7'd0, hot_valve, cold_valve}, 9'd0);
    step(1);
    pulse_tick();
    lit("fill_warm_valves", {7'd0, hot_valve, cold_valve}, 9'b11);
    lit("fill_hold_low", {8'd0, hold}, 9'd0);

    phase = 3'd2;
    step(1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) pulse_tick();
      lit("agit_en", {8'd0, motor_en}, {8'd0, en_pat[i]});
      if (en_pat[i]) lit("agit_dir", {8'd0, motor_dir}, {8'd0, dir_pat[i]});
    end

    phase = 3'd5;
    step(1);
    lit("spin_outs", {5'd0, drain_pump, motor_en, motor_fast, motor_dir}, 9'b1110);
    phase = 3'd0;
    step(1);
    lit("unlock_outs_off", {6'd0, drain_pump, motor_en, motor_fast}, 9'd0);
    lit("unlock_lock_held", {8'd0, lid_lock}, 9'd1);
    step(1);
    pulse_tick();
    lit("unlock_released", {8'd0, lid_lock}, 9'd0);

    phase = 3'd2;
    step(2);
    pulse_tick();
    lit("wash_running", {8'd0, motor_en}, 9'd1);
    lid_open = 1'b1;
    step(1);
    lit("lid_fault_outs", outs(), 9'b000000011);
    lid_open = 1'b0;
    step(5);
    lit("fault_sticky", {7'd0, fault, hold}, 9'b11);
    phase = 3'd0;
    step(1);
    lit("fault_cleared", {8'd0, fault}, 9'd0);

    phase = 3'd1; temp = 2'b11;
    step(2);
    pulse_tick();
    lit("bad_temp_no_valve", {7'd0, hot_valve, cold_valve}, 9'd0);
    step(1);
    lit("bad_temp_fault", {8'd0, fault}, 9'd1);
    phase = 3'd0; temp = 2'b00;
    step(1);
    lid_open = 1'b1; phase = 3'd1;
    step(3);
    lit("lid_open_idle", {6'd0, lid_lock, hold, fault}, 9'b010);
    lid_open = 1'b0; phase = 3'd0;
    step(2);

`ifdef ACT_LOCK_FEEDBACK_EN
    lid_locked = 1'b0; phase = 3'd1;
    step(2);
    pulse_tick(); step(1);
    pulse_tick(); step(1);
    lit("fb_waiting", {7'd0, lid_lock, fault}, 9'b10);
    pulse_tick();
    lit("fb_timeout_fault", {8'd0, fault}, 9'd1);
    phase = 3'd0; lid_locked = 1'b1;
    step(2);
`endif

    phase = 3'd5;
    step(2);
    pulse_tick();
    lit("spin_before_reset", {8'd0, motor_en}, 9'd1);
    #2 rst_n = 1'b0;
    #1 lit("async_reset_outs", outs(), 9'd0);
    @(negedge clk);
    rst_n = 1'b1; phase = 3'd0;
    step(2);

    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 29) == 0) phase = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) temp = 2'($urandom_range(0, 3));
      if (!lid_open) lid_open = ($urandom_range(0, 99) == 0);
      else lid_open = ($urandom_range(0, 3) != 0);
`ifdef ACT_LOCK_FEEDBACK_EN
      lid_locked = ($urandom_range(0, 19) != 0);
`endif
      @(negedge clk);
    end
    tick = 1'b0;
    step(2);
    chk_en = 1'b0;

    total_tests = lit_tests + cmp_tests;
    total_fails = lit_fails + cmp_fails;
    $display("[TB] %0d tests run, %0d failed", total_tests, total_fails);
    $finish;
  end
endmodule
